// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared constants for the execute-stage ALU: the datapath width and the
//   3-bit operation encodings. Imported by the interface, the combinational
//   core and the registered top level so every file agrees on the encoding.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W  = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
    localparam logic [OP_W-1:0] ALU_SUB  = 3'b001;
    localparam logic [OP_W-1:0] ALU_AND  = 3'b010;
    localparam logic [OP_W-1:0] ALU_OR   = 3'b011;
    localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
    localparam logic [OP_W-1:0] ALU_NOR  = 3'b101;
    localparam logic [OP_W-1:0] ALU_SLT  = 3'b110;
    localparam logic [OP_W-1:0] ALU_SLTU = 3'b111;

endpackage

// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if
//   Operand/result bundle of the execute-stage ALU.
//   Signals:
//     ALU_DA   [31:0]  operand A
//     ALU_DB   [31:0]  operand B
//     ALUOp    [2:0]   operation select
//     ALU_DC   [31:0]  registered result
//     ALU_zero         registered flag, 1 when ALU_DC == 0
//   Modports:
//     master  drives operands/opcode, observes result and flag
//     slave   the ALU itself
// ---------------------------------------------------------------------------
interface alu_if
    import alu_pkg::*;
();

    logic [ALU_W-1:0] ALU_DA;
    logic [ALU_W-1:0] ALU_DB;
    logic [OP_W-1:0]  ALUOp;
    logic [ALU_W-1:0] ALU_DC;
    logic             ALU_zero;

    modport master (
        output ALU_DA,
        output ALU_DB,
        output ALUOp,
        input  ALU_DC,
        input  ALU_zero
    );

    modport slave (
        input  ALU_DA,
        input  ALU_DB,
        input  ALUOp,
        output ALU_DC,
        output ALU_zero
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational ALU datapath. Produces the next result for the
//   current operands and opcode, plus the matching zero flag.
//   Ports:
//     da_i      [31:0]  operand A
//     db_i      [31:0]  operand B
//     op_i      [2:0]   operation select (alu_pkg encodings)
//     result_o  [31:0]  operation result, wrap-around arithmetic
//     zero_o            1 when result_o == 0
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] da_i,
    input  logic [ALU_W-1:0] db_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [ALU_W-1:0] result_o,
    output logic             zero_o
);

    logic sltBit;
    logic sltuBit;

    // Signed and unsigned less-than are computed side by side; only the
    // selected one reaches the result, zero-extended to the full width.
    always_comb begin
        sltBit  = ($signed(da_i) < $signed(db_i));
        sltuBit = (da_i < db_i);
    end

    // Operation select. Anything not decoded falls back to zero so an
    // unexpected opcode can never leak a stale or partial value.
    always_comb begin
        result_o = '0;
        unique case (op_i)
            ALU_ADD:  result_o = da_i + db_i;
            ALU_SUB:  result_o = da_i - db_i;
            ALU_AND:  result_o = da_i & db_i;
            ALU_OR:   result_o = da_i | db_i;
            ALU_XOR:  result_o = da_i ^ db_i;
            ALU_NOR:  result_o = ~(da_i | db_i);
            ALU_SLT:  result_o = {{(ALU_W-1){1'b0}}, sltBit};
            ALU_SLTU: result_o = {{(ALU_W-1){1'b0}}, sltuBit};
            default:  result_o = '0;
        endcase
    end

    // The flag is derived from the very result it accompanies, so the two
    // stay consistent once registered together.
    always_comb begin
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   32-bit execute-stage ALU with registered outputs: one-cycle latency,
//   one operation accepted every clock, no enable or handshake.
//   Ports:
//     clk     clock, state updates on the rising edge
//     reset   asynchronous active-high reset; forces ALU_DC=0, ALU_zero=1
//     bus     alu_if.slave: ALU_DA, ALU_DB, ALUOp in; ALU_DC, ALU_zero out
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    logic [ALU_W-1:0] dc_d;
    logic [ALU_W-1:0] dc_q;
    logic             zero_d;
    logic             zero_q;

    alu_core u_core (
        .da_i     (bus.ALU_DA),
        .db_i     (bus.ALU_DB),
        .op_i     (bus.ALUOp),
        .result_o (dc_d),
        .zero_o   (zero_d)
    );

    // Output register. The reset value is a zero result, so the flag resets
    // high to stay consistent with it; any pending result is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dc_q   <= '0;
            zero_q <= 1'b1;
        end else begin
            dc_q   <= dc_d;
            zero_q <= zero_d;
        end
    end

    assign bus.ALU_DC   = dc_q;
    assign bus.ALU_zero = zero_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//   Directed, table-driven bench for the registered ALU, plus hand-written
//   sequences for reset, latency, back-to-back issue and mid-run reset.
// ---------------------------------------------------------------------------
module tb_alu;
    import alu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] da;
        logic [31:0] db;
        logic [31:0] expDc;
        logic        expZero;
    } vector_t;

    logic clk;
    logic reset;
    int   totalCount;
    int   badCount;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one operation onto the bus.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] da, input logic [31:0] db);
        bus.ALUOp  = op;
        bus.ALU_DA = da;
        bus.ALU_DB = db;
    endtask

    // Compare the registered outputs against expected values.
    task automatic checkOutput(input string name, input logic [31:0] expDc, input logic expZero);
        totalCount++;
        if (bus.ALU_DC !== expDc || bus.ALU_zero !== expZero) begin
            badCount++;
            $display("[TB] FAIL %s: actual DC=%h zero=%b required DC=%h zero=%b",
                     name, bus.ALU_DC, bus.ALU_zero, expDc, expZero);
        end
    endtask

    vector_t vecs[$];
    logic [31:0] b2bExp[8];

    initial begin
        totalCount = 0;
        badCount   = 0;

        // Vector table: op, DA, DB, expected DC, expected zero.
        vecs.push_back('{ALU_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0});
        vecs.push_back('{ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0});
        vecs.push_back('{ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0});
        vecs.push_back('{ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0});
        vecs.push_back('{ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b0});
        vecs.push_back('{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{ALU_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0});
        vecs.push_back('{ALU_SLTU, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SLT,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SLTU, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SLT,  32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0});
        vecs.push_back('{ALU_SLTU, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
        vecs.push_back('{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
        vecs.push_back('{ALU_SUB,  32'h0000_0013, 32'h0000_0025, 32'hFFFF_FFEE, 1'b0});

        // Back-to-back expectations for DA=0x13, DB=0x25 across opcodes 0..7.
        b2bExp[0] = 32'h0000_0038;
        b2bExp[1] = 32'hFFFF_FFEE;
        b2bExp[2] = 32'h0000_0001;
        b2bExp[3] = 32'h0000_0037;
        b2bExp[4] = 32'h0000_0036;
        b2bExp[5] = 32'hFFFF_FFC8;
        b2bExp[6] = 32'h0000_0001;
        b2bExp[7] = 32'h0000_0001;

        // Reset asserted with live operands: outputs clear before any edge.
        reset = 1'b1;
        applyStimulus(ALU_ADD, 32'd5, 32'd3);
        #1;
        checkOutput("reset_no_clock", 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset_hold_edge%0d", i), 32'h0, 1'b1);
        end

        // Release reset away from the edge, then check one-cycle latency.
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(ALU_SUB, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("latency_sub_equal", 32'h0, 1'b1);
        @(negedge clk);
        applyStimulus(ALU_SUB, 32'd2, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("latency_sub_one", 32'h1, 1'b0);

        // Changing inputs between edges must not disturb the held result.
        applyStimulus(ALU_ADD, 32'h1234_0000, 32'h0000_5678);
        #2;
        checkOutput("hold_between_edges", 32'h1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("capture_after_change", 32'h1234_5678, 1'b0);

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].da, vecs[i].db);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_op%0d", i, vecs[i].op), vecs[i].expDc, vecs[i].expZero);
        end

        // Back-to-back: new opcode every cycle, each result one edge later.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            applyStimulus(3'(i), 32'h0000_0013, 32'h0000_0025);
            @(posedge clk);
            #1;
            checkOutput($sformatf("b2b_op%0d", i), b2bExp[i], 1'b0);
        end

        // Mid-run reset between edges: immediate clear, pending result lost.
        @(negedge clk);
        applyStimulus(ALU_OR, 32'h0000_00A0, 32'h0000_000B);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrun_reset_immediate", 32'h0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("midrun_reset_discard", 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_midrun_reset", 32'h0000_00AB, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
